// File: rtl/fifo_16to32_ctl_pkg.sv
// Shared constants and types for the 16-bit-in / 32-bit-out FIFO controller.
// Depths, pointer widths and data widths live here so the controller and its memory agree.
package fifo_16to32_ctl_pkg;

  localparam int HW_DEPTH   = 1024;  // halfword slots on the narrow port
  localparam int WORD_DEPTH = 512;   // word slots on the wide port
  localparam int WP_W       = 11;    // halfword address + wrap bit
  localparam int RP_W       = 10;    // word address + wrap bit
  localparam int HW_W       = 16;
  localparam int WORD_W     = 32;
  localparam int ADR0_W     = WP_W - 1;
  localparam int ADR1_W     = RP_W - 1;
  localparam int LEVEL_W    = WP_W;

  typedef logic [WP_W-1:0]    wp_t;
  typedef logic [RP_W-1:0]    rp_t;
  typedef logic [LEVEL_W-1:0] level_t;

  // One read pointer step frees two halfwords, so the read pointer is scaled
  // into halfword units before the modulo-2^11 difference.
  function automatic level_t fill_level(input wp_t wp, input rp_t rp);
    return level_t'(wp - {rp, 1'b0});
  endfunction

endpackage

// File: rtl/fifo_16to32_ctl.sv
// Width-converting FIFO controller: halfword pushes on a 1024x16 port, word pops
// on a 512x32 port of an external dual-port memory, both ports on clk.
module fifo_16to32_ctl
  import fifo_16to32_ctl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  logic [HW_W-1:0]      i_push_data,
  output logic                 o_full,
  input  logic                 i_pop,
  output logic                 o_empty,
  output logic                 o_pop_valid,
  output logic [WORD_W-1:0]    o_pop_data,
  output logic [LEVEL_W-1:0]   o_level,
  output logic                 o_mem_en0,
  output logic [1:0]           o_mem_wen0,
  output logic [ADR0_W-1:0]    o_mem_adr0,
  output logic [HW_W-1:0]      o_mem_wdata0,
  output logic                 o_mem_en1,
  output logic [ADR1_W-1:0]    o_mem_adr1,
  input  logic [WORD_W-1:0]    i_mem_rdata1
);

  wp_t                wp;
  rp_t                rp;
  level_t             level;
  logic               push_acc;
  logic               pop_acc;
  logic [MEM_LAT-1:0] rd_pipe;

  // Status is derived only from the registered pointers, so a pop in the same
  // cycle never frees space for a push and vice versa.
  assign level   = fill_level(wp, rp);
  assign o_level = level;
  assign o_full  = (level == level_t'(HW_DEPTH));
  assign o_empty = (level < level_t'(2));

  assign push_acc = i_push & ~o_full  & ~i_flush & ~rst;
  assign pop_acc  = i_pop  & ~o_empty & ~i_flush & ~rst;

  // NOTE: every output is assigned a default first so no path leaves a latch.
  always_comb begin
    o_mem_en0    = 1'b0;
    o_mem_wen0   = 2'b00;
    o_mem_adr0   = wp[ADR0_W-1:0];
    o_mem_wdata0 = i_push_data;
    o_mem_en1    = 1'b0;
    o_mem_adr1   = rp[ADR1_W-1:0];
    if (push_acc) begin
      o_mem_en0  = 1'b1;
      o_mem_wen0 = 2'b11;
    end
    if (pop_acc) begin
      o_mem_en1 = 1'b1;
    end
  end

  // Even halfword addresses map to the upper lane of the wide word, so the read
  // data already has the older halfword on top and passes straight through.
  assign o_pop_valid = rd_pipe[MEM_LAT-1];
  assign o_pop_data  = i_mem_rdata1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      rd_pipe <= '0;
    end else begin
      if (i_flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push_acc) wp <= wp + wp_t'(1);
        if (pop_acc)  rp <= rp + rp_t'(1);
      end
      // A read already issued to the memory still returns across a flush.
      rd_pipe[0] <= pop_acc;
      for (int i = 1; i < MEM_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fifo_16to32_ctl.sv
// Directed and constrained-random checks of fifo_16to32_ctl against a
// behavioural 1024x16 / 512x32 dual-port memory and a halfword queue model.
module tb_fifo_16to32_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        i_push;
  logic [15:0] i_push_data;
  logic        o_full;
  logic        i_pop;
  logic        o_empty;
  logic        o_pop_valid;
  logic [31:0] o_pop_data;
  logic [10:0] o_level;
  logic        o_mem_en0;
  logic [1:0]  o_mem_wen0;
  logic [9:0]  o_mem_adr0;
  logic [15:0] o_mem_wdata0;
  logic        o_mem_en1;
  logic [8:0]  o_mem_adr1;
  logic [31:0] i_mem_rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_16to32_ctl #(.MEM_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (i_flush),
    .i_push       (i_push),
    .i_push_data  (i_push_data),
    .o_full       (o_full),
    .i_pop        (i_pop),
    .o_empty      (o_empty),
    .o_pop_valid  (o_pop_valid),
    .o_pop_data   (o_pop_data),
    .o_level      (o_level),
    .o_mem_en0    (o_mem_en0),
    .o_mem_wen0   (o_mem_wen0),
    .o_mem_adr0   (o_mem_adr0),
    .o_mem_wdata0 (o_mem_wdata0),
    .o_mem_en1    (o_mem_en1),
    .o_mem_adr1   (o_mem_adr1),
    .i_mem_rdata1 (i_mem_rdata1)
  );

  // Behavioural dual-port memory: even halfword address is the upper lane.
  logic [15:0] mem [1024];

  always @(posedge clk) begin
    if (o_mem_en0 && o_mem_wen0 == 2'b11) mem[o_mem_adr0] <= o_mem_wdata0;
  end

  always @(posedge clk) begin
    if (o_mem_en1) i_mem_rdata1 <= {mem[{o_mem_adr1, 1'b0}], mem[{o_mem_adr1, 1'b1}]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] d);
    i_push      = 1'b1;
    i_push_data = d;
    step();
    i_push = 1'b0;
  endtask

  function automatic logic [15:0] fill_hw(input int i);
    return 16'(i * 3 + 5);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stream-test model state
  logic [15:0] q[$];
  logic [31:0] exp_word;
  logic        do_push, do_pop, push_ok, pop_ok;
  logic [15:0] seq;
  int          pushed, popped, cyc, k;

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_push = 1'b0; i_push_data = '0; i_pop = 1'b0;
    #1;
    repeat (2) step();

    // Reset state
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full",  32'(o_full), 32'd0);
    check("rst_valid", 32'(o_pop_valid), 32'd0);
    check("rst_en0",   32'(o_mem_en0), 32'd0);
    check("rst_wen0",  32'(o_mem_wen0), 32'd0);
    check("rst_en1",   32'(o_mem_en1), 32'd0);
    rst = 1'b0;

    // Two halfwords then one word out
    i_push = 1'b1; i_push_data = 16'h1111;
    #1;
    check("push_en0",   32'(o_mem_en0), 32'd1);
    check("push_wen0",  32'(o_mem_wen0), 32'd3);
    check("push_adr0",  32'(o_mem_adr0), 32'd0);
    check("push_wdata", 32'(o_mem_wdata0), 32'h1111);
    step();
    check("lvl1", 32'(o_level), 32'd1);
    check("lvl1_empty", 32'(o_empty), 32'd1);
    // Pop in the same cycle as the completing push sees the pre-edge empty flag
    i_push_data = 16'h2222; i_pop = 1'b1;
    #1;
    check("pop_on_empty_en1", 32'(o_mem_en1), 32'd0);
    step();
    i_push = 1'b0;
    check("lvl2", 32'(o_level), 32'd2);
    check("no_valid_empty_pop", 32'(o_pop_valid), 32'd0);
    #1;
    check("pop_en1",  32'(o_mem_en1), 32'd1);
    check("pop_adr1", 32'(o_mem_adr1), 32'd0);
    step();
    i_pop = 1'b0;
    check("pop_valid", 32'(o_pop_valid), 32'd1);
    check("pop_data",  o_pop_data, 32'h11112222);
    check("lvl0",      32'(o_level), 32'd0);
    step();
    check("valid_one_cycle", 32'(o_pop_valid), 32'd0);

    // Odd trailing halfword is not poppable
    push_one(16'hAAAA);
    i_pop = 1'b1;
    #1;
    check("odd_en1", 32'(o_mem_en1), 32'd0);
    step();
    i_pop = 1'b0;
    check("odd_valid", 32'(o_pop_valid), 32'd0);
    check("odd_level", 32'(o_level), 32'd1);
    check("odd_empty", 32'(o_empty), 32'd1);

    // Flush wins over a push in the same cycle
    i_flush = 1'b1; i_push = 1'b1; i_push_data = 16'hBEEF;
    #1;
    check("flush_push_en0", 32'(o_mem_en0), 32'd0);
    step();
    i_flush = 1'b0; i_push = 1'b0;
    check("flush_level", 32'(o_level), 32'd0);

    // Fill to full, drop extra push, drain in order
    for (int i = 0; i < 1024; i++) push_one(fill_hw(i));
    check("full_flag",  32'(o_full), 32'd1);
    check("full_level", 32'(o_level), 32'd1024);
    i_push = 1'b1; i_push_data = 16'hDEAD; i_pop = 1'b1;
    #1;
    check("full_push_en0", 32'(o_mem_en0), 32'd0);
    check("full_pop_en1",  32'(o_mem_en1), 32'd1);
    step();
    i_push = 1'b0;
    check("full_pop_level", 32'(o_level), 32'd1022);
    k = 0;
    for (int c = 0; c < 520; c++) begin
      if (o_pop_valid) begin
        check($sformatf("drain_w%0d", k), o_pop_data, {fill_hw(2 * k), fill_hw(2 * k + 1)});
        k++;
      end
      if (o_empty) i_pop = 1'b0;
      step();
    end
    i_pop = 1'b0;
    check("drain_count", 32'(k), 32'd512);
    check("drain_level", 32'(o_level), 32'd0);
    check("drain_empty", 32'(o_empty), 32'd1);

    // Level 3, simultaneous push and pop (wp=1027, rp=512 here)
    push_one(16'hB001); push_one(16'hB002); push_one(16'hB003);
    i_push = 1'b1; i_push_data = 16'hB004; i_pop = 1'b1;
    #1;
    check("pp_adr0", 32'(o_mem_adr0), 32'd3);
    check("pp_adr1", 32'(o_mem_adr1), 32'd0);
    step();
    i_push = 1'b0;
    check("pp_level", 32'(o_level), 32'd2);
    check("pp_data",  o_pop_data, 32'hB001B002);
    check("pp_valid", 32'(o_pop_valid), 32'd1);
    step();
    i_pop = 1'b0;
    check("pp_data2", o_pop_data, 32'hB003B004);
    i_push = 1'b1; i_push_data = 16'hB005;
    #1;
    check("pp_next_adr0", 32'(o_mem_adr0), 32'd4);
    i_push = 1'b0;

    // Level 6, pop then flush: the issued read still returns
    i_flush = 1'b1; step(); i_flush = 1'b0;
    for (int i = 0; i < 6; i++) push_one(16'hC000 + 16'(i));
    check("lvl6", 32'(o_level), 32'd6);
    i_pop = 1'b1; step(); i_pop = 1'b0;
    i_flush = 1'b1;
    #1;
    check("flush_valid", 32'(o_pop_valid), 32'd1);
    check("flush_data",  o_pop_data, 32'hC000C001);
    step();
    i_flush = 1'b0;
    check("post_flush_level", 32'(o_level), 32'd0);
    check("post_flush_empty", 32'(o_empty), 32'd1);
    check("post_flush_valid", 32'(o_pop_valid), 32'd0);

    // Random stream of 5000 halfwords against a queue model
    q.delete(); seq = 16'h5000; pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 5000 || q.size() >= 2) && cyc < 40000) begin
      do_push = (pushed < 5000) && ($urandom_range(0, 99) < 70);
      do_pop  = ($urandom_range(0, 99) < 35);
      push_ok = do_push && (q.size() < 1024);
      pop_ok  = do_pop && (q.size() >= 2);
      i_push = do_push; i_push_data = seq; i_pop = do_pop;
      if (pop_ok) begin
        exp_word = {q[0], q[1]};
        void'(q.pop_front());
        void'(q.pop_front());
        popped++;
      end
      if (push_ok) begin
        q.push_back(seq);
        seq++;
        pushed++;
      end
      step();
      i_push = 1'b0; i_pop = 1'b0;
      check("stream_valid", 32'(o_pop_valid), 32'(pop_ok));
      if (pop_ok) check($sformatf("stream_w%0d", popped), o_pop_data, exp_word);
      check("stream_level", 32'(o_level), 32'(q.size()));
      cyc++;
    end
    check("stream_pushed", 32'(pushed), 32'd5000);
    check("stream_popped", 32'(popped), 32'd2500);

    // Reset beats a pop requested in the same cycle
    push_one(16'hE001); push_one(16'hE002);
    i_pop = 1'b1; rst = 1'b1;
    #1;
    check("rst_pop_en1", 32'(o_mem_en1), 32'd0);
    step();
    i_pop = 1'b0; rst = 1'b0;
    check("rst_pop_valid", 32'(o_pop_valid), 32'd0);
    check("rst_pop_level", 32'(o_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_16to32_ctl.md
FIFO_16TO32_CTL -- requirements
Module: fifo_16to32_ctl

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles from wide-port address to o_mem-side read data; only value 1 supported.
REQ-002 clk  input  1  sole clock; one clock; all logic on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 i_flush  input  1  synchronous FIFO clear.
REQ-005 i_push  input  1  write one 16-bit halfword.
REQ-006 i_push_data  input  16  halfword to write.
REQ-007 o_full  output  1  no halfword space; push ignored.
REQ-008 i_pop  input  1  read one 32-bit word.
REQ-009 o_empty  output  1  fewer than 2 halfwords stored; pop ignored.
REQ-010 o_pop_valid  output  1  o_pop_data valid this cycle.
REQ-011 o_pop_data  output  32  popped word {older halfword, newer halfword}.
REQ-012 o_level  output  11  stored halfwords, 0..1024.
REQ-013 o_mem_en0  output  1  narrow-port enable.
REQ-014 o_mem_wen0  output  2  narrow-port byte write enables.
REQ-015 o_mem_adr0  output  10  narrow-port halfword address.
REQ-016 o_mem_wdata0  output  16  narrow-port write data.
REQ-017 o_mem_en1  output  1  wide-port enable.
REQ-018 o_mem_adr1  output  9  wide-port word address.
REQ-019 i_mem_rdata1  input  32  wide-port read data, 1 cycle after o_mem_en1.

Function
REQ-020 Write pointer wp is 11 bits (halfword address + wrap bit); read pointer rp is 10 bits (word address + wrap bit).
REQ-021 o_level = wp - {rp, 1'b0}, modulo 2^11; o_full = (o_level == 1024); o_empty = (o_level < 2); all three combinational from registered pointers.
REQ-022 Accepted push (i_push & ~o_full & ~i_flush): o_mem_en0=1, o_mem_wen0=2'b11, o_mem_adr0=wp[9:0], o_mem_wdata0=i_push_data, same cycle; wp increments at the edge.
REQ-023 Non-accepted push: o_mem_en0=0, o_mem_wen0=0; wp unchanged.
REQ-024 Accepted pop (i_pop & ~o_empty & ~i_flush): o_mem_en1=1, o_mem_adr1=rp[8:0], same cycle; rp increments at the edge.
REQ-025 o_pop_valid asserts exactly one cycle after each accepted pop, with o_pop_data = i_mem_rdata1 passed through combinationally; otherwise o_pop_valid=0.
REQ-026 Halfword at even address lands in bits [31:16] of the word; o_pop_data[31:16] is the earlier-pushed halfword.
REQ-027 Simultaneous accepted push and pop: both performed; o_level changes by +1-2 = -1.
REQ-028 o_full and o_empty are evaluated on pre-edge state: push when full is dropped even if a pop is accepted the same cycle; pop when empty is dropped even if a push completes a word the same cycle.
REQ-029 Word completed by push at cycle t is poppable from cycle t+1.
REQ-030 Pointer wrap: wp 2047->0 and rp 1023->0; address bits wrap 1023->0 / 511->0 with wrap bit toggling.
REQ-031 i_flush: both pointers zero at the edge; push/pop same cycle ignored; o_pop_valid for a pop accepted the previous cycle still asserts.
REQ-032 An odd trailing halfword remains stored, not poppable, until its partner is pushed or a flush occurs.

Reset
REQ-033 On rst: wp=0, rp=0, o_pop_valid=0; hence o_empty=1, o_full=0, o_level=0, o_mem_en0=0, o_mem_wen0=0, o_mem_en1=0.
REQ-034 rst has priority over i_flush, i_push, i_pop; a pop accepted the cycle before rst yields no o_pop_valid.

Structure
REQ-035 Shared package holds FIFO depth constants (1024 halfwords, 512 words), pointer widths (11, 10), and halfword/word widths (16, 32).
REQ-036 No sub-module; storage is the parent-instantiated 1024x16/512x32 dual-port memory, both ports on clk.

Verification
REQ-037 Reset, then push 0x1111, 0x2222, pop -> o_pop_valid next cycle, o_pop_data=0x11112222, o_level 2->0.
REQ-038 Push 0xAAAA only, pop -> pop ignored, o_empty=1, o_level=1, no o_pop_valid.
REQ-039 Push 1024 halfwords -> o_full=1, o_level=1024; extra push 0xDEAD dropped; 512 pops return data in order, no 0xDEAD.
REQ-040 Level 3, push and pop same cycle -> level 2, correct word returned, next push lands at correct address.
REQ-041 Stream 5000 halfwords with random push/pop -> pointers wrap, all words in order, no loss/duplicate.
REQ-042 Level 6, pop then i_flush next cycle -> o_pop_valid with correct word, then o_level=0, o_empty=1.
